kuznechik_block_ctrl: RTL and testbench
=======================================

# kuznechik_block_ctrl

Sequencer for single-block Kuznyechik (GOST R 34.12-2015) encryption. It drives the existing `key_calculation` unit through its enable/finish handshake and caches the ten round keys. It then runs nine X-S-L rounds plus a final X over one shared `L_convertion` instance, using its own 128-bit state register. It sits between the host-side block/key handshakes and the round datapath.

## Interface
- No parameters. Round count (9) and key count (10) are fixed constants.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_in` in 256: cipher key; K1 = `[255:128]`.
- `key_load` in 1: key request, sampled only while `key_ready`=1.
- `key_ready` out 1: controller idle and able to accept `key_load`.
- `keys_ok` out 1: cached round keys are valid.
- `blk_in` in 128: plaintext block.
- `blk_valid` in 1 / `blk_ready` out 1: block handshake; transfer when both are 1.
- `out_data` out 128: ciphertext, held stable while `out_valid`=1.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `kc_enable` out 1, `kc_key` out 256, `kc_finish` in 1, `kc_keys` in 1280: `key_calculation` port; `key_1` is at `[1279:1152]`, `key_10` at `[127:0]`.
- `lc_enable` out 1, `lc_word` out 128, `lc_out` in 128, `lc_finish` in 1: `L_convertion` port; `lc_word` = state register.

## Operation
- States: IDLE, KEY_RUN, KEY_REL, XOR, SUB, LIN, FINAL, OUT.
- `key_ready` = IDLE and `kc_finish`=0.
- `blk_ready` = IDLE and `keys_ok` and not `key_load`.
- **IDLE**
  - `key_load` and `key_ready`: latch `kc_key`←`key_in`, clear `keys_ok`, go to KEY_RUN.
  - Else, on a block transfer: state←`blk_in`, round←0, go to XOR.
  - `key_load` has priority over `blk_valid` in the same cycle.
- **KEY_RUN**: `kc_enable`=1. When `kc_finish`=1, copy `kc_keys` into ten internal key registers and go to KEY_REL.
- **KEY_REL**: `kc_enable`=0. Wait for `kc_finish`=0, then set `keys_ok`=1 and go to IDLE.
- **XOR**: wait for `lc_finish`=0, then state←state ^ K[round+1] and go to SUB.
- **SUB**: state←S(state), 16 byte-parallel S-boxes. Go to LIN with `lc_enable` registered to 1.
- **LIN**
  - Hold `lc_enable`=1 until `lc_finish`=1.
  - On finish: state←`lc_out`, `lc_enable`←0, round←round+1.
  - If round was 8, go to FINAL; else go to XOR.
- **FINAL**: state←state ^ K10, `out_valid`←1, go to OUT.
- **OUT**: `out_data`=state. When `out_ready`=1, `out_valid`←0 and go to IDLE.
- `key_load` outside IDLE is ignored; no queuing.
- Round counter is 4 bits, range 0..8, no wrap.
- XOR/S/L are full 128-bit operations; no carries.

## Timing
- Reset values: all outputs 0, state IDLE, `keys_ok`=0, round keys 0.
  - `key_ready` goes high once `kc_finish`=0, since `key_calculation` has no reset.
- Reset mid-operation:
  - Abort immediately; drop `kc_enable` and `lc_enable` on the reset edge.
  - Discard any in-flight block and the partial key state.
- Key load latency: 1 cycle into KEY_RUN, plus the `key_calculation` run time, plus KEY_REL cycles until `kc_finish` falls (≥2 cycles).
- Block latency, from the accept edge to `out_valid` rising: 9·(2 + T_L) + 1 cycles.
  - T_L is the LIN dwell per round, including any XOR wait for `lc_finish` low.
- `out_valid` stays high with `out_data` stable until `out_ready`. `blk_ready` stays 0 until OUT exits.
- `lc_enable` is never re-asserted while `lc_finish`=1. `kc_enable` is never asserted while `kc_finish`=1.

## Structure
- Package `kuznechik_pkg`:
  - `BLOCK_W`=128, `KEY_W`=256, `N_ROUNDS`=9, `N_KEYS`=10.
  - State enum.
  - Function to slice K[i] out of the 1280-bit bundle.
- Sub-module `s_layer`: 16 `table_convertion` instances, 128 in / 128 out, combinational. Instantiated once.
- `key_calculation` and `L_convertion` are instantiated in the parent, not inside this block.

## Test plan
- **Key load**
  - Stimulus: `key_in`=8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef.
  - Response: `keys_ok`=1; K1=8899aabbccddeeff0011223344556677, K2=fedcba98765432100123456789abcdef.
- **Encrypt**: after the key load above, `blk_in`=1122334455667700ffeeddccbbaa9988 → `out_data`=7f679d90bebc24305a468d42b9d4edcd.
- **Back-pressure**: hold `out_ready`=0 for 20 cycles → `out_data` stable, `blk_ready`=0 throughout; the next block is accepted one cycle after `out_ready`.
- **Simultaneous key_load and blk_valid in IDLE**: key load wins; `blk_ready`=0 that cycle; the block is accepted only after `keys_ok` returns to 1.
- **No key**: `blk_valid`=1 with `keys_ok`=0 → `blk_ready`=0 and no `lc_enable` activity.
- **Reset mid-round 4**: `rst_n`=0 for 1 cycle → all outputs 0 next cycle, `keys_ok`=0; a fresh key load plus block reproduces the test-vector ciphertext.

Source files
------------

// File: rtl/kuznechik_pkg.sv
// Shared widths, FSM encoding and round-key slicing for the Kuznyechik block sequencer.
package kuznechik_pkg;

    localparam int BLOCK_W  = 128;
    localparam int KEY_W    = 256;
    localparam int N_ROUNDS = 9;
    localparam int N_KEYS   = 10;

    typedef enum logic [2:0] {
        IDLE,
        KEY_RUN,
        KEY_REL,
        XOR,
        SUB,
        LIN,
        FINAL,
        OUT
    } state_e;

    // K[i], 1-based: K1 occupies the top 128 bits of the bundle, K10 the bottom.
    function automatic logic [BLOCK_W-1:0] round_key(
        input logic [N_KEYS*BLOCK_W-1:0] keys,
        input int                        i
    );
        return keys[(N_KEYS - i) * BLOCK_W +: BLOCK_W];
    endfunction

endpackage

// File: rtl/kuznechik_block_ctrl_if.sv
// Host-side key / block / result handshakes of the Kuznyechik block sequencer.
interface kuznechik_block_ctrl_if;
    import kuznechik_pkg::*;

    logic [KEY_W-1:0]   key_in;
    logic               key_load;
    logic               key_ready;
    logic               keys_ok;
    logic [BLOCK_W-1:0] blk_in;
    logic               blk_valid;
    logic               blk_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output key_in, key_load, blk_in, blk_valid, out_ready,
        input  key_ready, keys_ok, blk_ready, out_data, out_valid
    );

    modport slave (
        input  key_in, key_load, blk_in, blk_valid, out_ready,
        output key_ready, keys_ok, blk_ready, out_data, out_valid
    );

endinterface

// File: rtl/kuznechik_block_ctrl_s_layer.sv
// Nonlinear S layer: the Kuznyechik pi substitution applied to all 16 bytes in parallel.

// One pi substitution box, byte in / byte out.
module table_convertion (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] PI = {
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    assign out_byte = PI[in_byte];
endmodule

// Sixteen independent byte boxes across the 128-bit state.
module s_layer
    import kuznechik_pkg::*;
(
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);
    for (genvar i = 0; i < BLOCK_W / 8; i++) begin : g_sbox
        table_convertion u_tc (
            .in_byte  (din[8*i +: 8]),
            .out_byte (dout[8*i +: 8])
        );
    end
endmodule

// File: rtl/kuznechik_block_ctrl.sv
// Single-block Kuznyechik encryption sequencer: runs the external key schedule once,
// caches the ten round keys, then steps nine X-S-L rounds plus a closing X through
// one shared L unit, holding the working block in its own state register.
module kuznechik_block_ctrl
    import kuznechik_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    kuznechik_block_ctrl_if.slave     host,
    output logic                      kc_enable,
    output logic [KEY_W-1:0]          kc_key,
    input  logic                      kc_finish,
    input  logic [N_KEYS*BLOCK_W-1:0] kc_keys,
    output logic                      lc_enable,
    output logic [BLOCK_W-1:0]        lc_word,
    input  logic [BLOCK_W-1:0]        lc_out,
    input  logic                      lc_finish
);

    state_e                         state, state_n;
    logic [BLOCK_W-1:0]             st, st_sbox;
    logic [3:0]                     rnd;
    logic [N_KEYS-1:0][BLOCK_W-1:0] rk;
    logic [KEY_W-1:0]               kc_key_q;
    logic                           keys_ok_q, out_valid_q, lc_en_q;
    logic                           in_idle, key_go, blk_go;

    s_layer u_s_layer (
        .din  (st),
        .dout (st_sbox)
    );

    // key_calculation has no reset, so a stale finish must clear before a new key is taken
    assign in_idle        = (state == IDLE);
    assign host.key_ready = in_idle && !kc_finish;
    assign host.blk_ready = in_idle && keys_ok_q && !host.key_load;
    assign key_go         = host.key_load && host.key_ready;
    assign blk_go         = host.blk_valid && host.blk_ready;

    assign host.keys_ok   = keys_ok_q;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = st;
    assign kc_enable      = (state == KEY_RUN);
    assign kc_key         = kc_key_q;
    assign lc_enable      = lc_en_q;
    assign lc_word        = st;

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; key_load wins over a block in the same idle cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (key_go) state_n = KEY_RUN;
                     else if (blk_go) state_n = XOR;
            KEY_RUN: if (kc_finish) state_n = KEY_REL;
            KEY_REL: if (!kc_finish) state_n = IDLE;
            XOR:     if (!lc_finish) state_n = SUB;
            SUB:     state_n = LIN;
            LIN:     if (lc_finish) state_n = (rnd == 4'(N_ROUNDS - 1)) ? FINAL : XOR;
            FINAL:   state_n = OUT;
            OUT:     if (host.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, advanced per FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= '0;
            rnd         <= '0;
            rk          <= '0;
            kc_key_q    <= '0;
            keys_ok_q   <= 1'b0;
            out_valid_q <= 1'b0;
            lc_en_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_go) begin
                        kc_key_q  <= host.key_in;
                        keys_ok_q <= 1'b0;
                    end else if (blk_go) begin
                        st  <= host.blk_in;
                        rnd <= '0;
                    end
                end
                KEY_RUN: begin
                    if (kc_finish) begin
                        for (int i = 0; i < N_KEYS; i++) rk[i] <= round_key(kc_keys, i + 1);
                    end
                end
                KEY_REL: if (!kc_finish) keys_ok_q <= 1'b1;
                // waiting out the previous L finish keeps lc_enable off a high lc_finish
                XOR:     if (!lc_finish) st <= st ^ rk[rnd];
                SUB: begin
                    st      <= st_sbox;
                    lc_en_q <= 1'b1;
                end
                LIN: begin
                    if (lc_finish) begin
                        st      <= lc_out;
                        lc_en_q <= 1'b0;
                        rnd     <= rnd + 4'd1;
                    end
                end
                FINAL: begin
                    st          <= st ^ rk[N_KEYS-1];
                    out_valid_q <= 1'b1;
                end
                OUT:     if (host.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_block_ctrl.sv
// Directed bench for kuznechik_block_ctrl against the GOST R 34.12-2015 test vector,
// with behavioural stand-ins for key_calculation and L_convertion.
module tb_kuznechik_block_ctrl;
    import kuznechik_pkg::*;

    localparam logic [255:0] TEST_KEY =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [1279:0] RK_BUNDLE = {
        128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
    };
    localparam logic [0:15][7:0] LCOEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };
    localparam int KC_LAT = 5;
    // The L model raises finish one edge after enable, so LIN dwells LC_LAT+1 cycles.
    localparam int LC_LAT = 1;
    // Round 0: XOR 1 + SUB 1 + LIN; later rounds add one XOR cycle waiting for finish
    // to fall; then one FINAL cycle.
    localparam int EXP_LAT = (LC_LAT + 3) + (N_ROUNDS - 1) * (LC_LAT + 4) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           kc_enable, lc_enable;
    logic           kc_finish = 1'b0, lc_finish = 1'b0;
    logic [255:0]   kc_key;
    logic [1279:0]  kc_keys = '0;
    logic [127:0]   lc_word;
    logic [127:0]   lc_out = '0;
    int             kc_cnt = 0;
    int             lc_cnt = 0;
    int             checks = 0;
    int             errors = 0;

    kuznechik_block_ctrl_if host ();

    kuznechik_block_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host),
        .kc_enable (kc_enable),
        .kc_key    (kc_key),
        .kc_finish (kc_finish),
        .kc_keys   (kc_keys),
        .lc_enable (lc_enable),
        .lc_word   (lc_word),
        .lc_out    (lc_out),
        .lc_finish (lc_finish)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
        end
        return p;
    endfunction

    // L = sixteen applications of R; the new top byte is the linear combination.
    function automatic logic [127:0] l_xform(input logic [127:0] din);
        logic [127:0] v;
        logic [7:0]   acc;
        v = din;
        for (int r = 0; r < 16; r++) begin
            acc = '0;
            for (int j = 0; j < 16; j++) acc = acc ^ gmul(v[127-8*j -: 8], LCOEF[j]);
            v = {acc, v[127:8]};
        end
        return v;
    endfunction

    // key_calculation stand-in: no reset, finish held until enable drops.
    always @(posedge clk) begin
        if (!kc_enable) begin
            kc_finish <= 1'b0;
            kc_cnt    <= 0;
        end else if (!kc_finish) begin
            if (kc_cnt == KC_LAT - 1) begin
                kc_finish <= 1'b1;
                kc_keys   <= (kc_key == TEST_KEY) ? RK_BUNDLE : ~RK_BUNDLE;
            end else begin
                kc_cnt <= kc_cnt + 1;
            end
        end
    end

    // L_convertion stand-in.
    always @(posedge clk) begin
        if (!lc_enable) begin
            lc_finish <= 1'b0;
        end else if (!lc_finish) begin
            lc_out    <= l_xform(lc_word);
            lc_finish <= 1'b1;
        end
    end

    always @(posedge clk) if (lc_enable) lc_cnt <= lc_cnt + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input string tag, input logic [255:0] k);
        int n;
        n = 0;
        host.key_in   = k;
        host.key_load = 1'b1;
        tick();
        host.key_load = 1'b0;
        chk_bit({tag, "_kc_enable"}, kc_enable, 1'b1);
        chk_blk({tag, "_kc_key_hi"}, kc_key[255:128], k[255:128]);
        chk_blk({tag, "_kc_key_lo"}, kc_key[127:0], k[127:0]);
        chk_bit({tag, "_key_ready_busy"}, host.key_ready, 1'b0);
        while (!host.keys_ok && n < 100) begin
            tick();
            n++;
        end
        chk_bit({tag, "_keys_ok"}, host.keys_ok, 1'b1);
        chk_bit({tag, "_blk_ready"}, host.blk_ready, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!host.out_valid && lat < 1000) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input logic [127:0] pt, output int lat);
        int n;
        n = 0;
        host.blk_in    = pt;
        host.blk_valid = 1'b1;
        while (!host.blk_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        host.blk_valid = 1'b0;
        wait_out(lat);
    endtask

    task automatic drain();
        host.out_ready = 1'b1;
        tick();
        host.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, n, lc_base;
        logic          seen;
        logic          vld_all;
        logic [127:0]  first, diff;

        host.key_in    = '0;
        host.key_load  = 1'b0;
        host.blk_in    = '0;
        host.blk_valid = 1'b0;
        host.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk_bit("rst_keys_ok", host.keys_ok, 1'b0);
        chk_bit("rst_blk_ready", host.blk_ready, 1'b0);
        chk_bit("rst_out_valid", host.out_valid, 1'b0);
        chk_blk("rst_out_data", host.out_data, '0);
        chk_bit("rst_kc_enable", kc_enable, 1'b0);
        chk_bit("rst_lc_enable", lc_enable, 1'b0);
        chk_bit("rst_key_ready", host.key_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // No key loaded: block must be refused and L never started
        host.blk_in    = PT;
        host.blk_valid = 1'b1;
        lc_base        = lc_cnt;
        seen           = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | host.blk_ready;
        end
        host.blk_valid = 1'b0;
        chk_bit("nokey_blk_ready", seen, 1'b0);
        chk_int("nokey_lc_activity", lc_cnt - lc_base, 0);
        chk_bit("nokey_out_valid", host.out_valid, 1'b0);

        // Key load, then the reference encryption
        load_key("key1", TEST_KEY);
        run_block(PT, lat);
        chk_int("enc_latency", lat, EXP_LAT);
        chk_bit("enc_out_valid", host.out_valid, 1'b1);
        chk_blk("enc_out_data", host.out_data, CT);

        // Back-pressure: result held, no new block while out_ready is low
        first   = host.out_data;
        diff    = '0;
        seen    = 1'b0;
        vld_all = 1'b1;
        host.blk_in    = PT;
        host.blk_valid = 1'b1;
        repeat (20) begin
            tick();
            diff    = diff | (host.out_data ^ first);
            seen    = seen | host.blk_ready;
            vld_all = vld_all & host.out_valid;
        end
        chk_blk("bp_out_data_stable", diff, '0);
        chk_bit("bp_blk_ready", seen, 1'b0);
        chk_bit("bp_out_valid_held", vld_all, 1'b1);
        host.out_ready = 1'b1;
        tick();
        host.out_ready = 1'b0;
        chk_bit("bp_release_out_valid", host.out_valid, 1'b0);
        chk_bit("bp_release_blk_ready", host.blk_ready, 1'b1);
        tick();
        host.blk_valid = 1'b0;
        chk_bit("bp_accepted_blk_ready", host.blk_ready, 1'b0);
        wait_out(lat);
        chk_int("bp_second_latency", lat, EXP_LAT);
        chk_blk("bp_second_out_data", host.out_data, CT);
        drain();
        chk_bit("bp_drain_out_valid", host.out_valid, 1'b0);

        // key_load and blk_valid together in IDLE: key load wins
        host.key_in    = TEST_KEY;
        host.key_load  = 1'b1;
        host.blk_in    = PT;
        host.blk_valid = 1'b1;
        #1;
        chk_bit("simul_blk_ready", host.blk_ready, 1'b0);
        chk_bit("simul_key_ready", host.key_ready, 1'b1);
        tick();
        host.key_load = 1'b0;
        chk_bit("simul_keys_ok_cleared", host.keys_ok, 1'b0);
        chk_bit("simul_kc_enable", kc_enable, 1'b1);
        lc_base = lc_cnt;
        n       = 0;
        while (!host.blk_ready && n < 100) begin
            tick();
            n++;
        end
        chk_bit("simul_keys_ok_at_accept", host.keys_ok, 1'b1);
        chk_int("simul_lc_before_accept", lc_cnt - lc_base, 0);
        tick();
        host.blk_valid = 1'b0;
        wait_out(lat);
        chk_int("simul_latency", lat, EXP_LAT);
        chk_blk("simul_out_data", host.out_data, CT);
        drain();

        // Reset part way into the fifth round
        host.blk_in    = PT;
        host.blk_valid = 1'b1;
        tick();
        host.blk_valid = 1'b0;
        repeat (20) tick();
        chk_bit("mid_out_valid", host.out_valid, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_bit("midrst_keys_ok", host.keys_ok, 1'b0);
        chk_bit("midrst_out_valid", host.out_valid, 1'b0);
        chk_blk("midrst_out_data", host.out_data, '0);
        chk_bit("midrst_kc_enable", kc_enable, 1'b0);
        chk_bit("midrst_lc_enable", lc_enable, 1'b0);
        chk_bit("midrst_blk_ready", host.blk_ready, 1'b0);
        chk_blk("midrst_kc_key", kc_key[255:128], '0);
        rst_n = 1'b1;
        tick();
        chk_bit("midrst_key_ready", host.key_ready, 1'b1);
        load_key("key2", TEST_KEY);
        run_block(PT, lat);
        chk_int("post_rst_latency", lat, EXP_LAT);
        chk_blk("post_rst_out_data", host.out_data, CT);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
